// File: rtl/sram_axi4_pkg.sv
// rtl/sram_axi4_pkg.sv - shared types for the sram_axi4_s slave memory
package sram_axi4_pkg;
  localparam int AXI_BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_BEAT} r_state_t;
endpackage

// File: rtl/sram_dp_array.sv
// rtl/sram_dp_array.sv - DEPTH x DATA_W array, byte-enabled write port, registered read port
module sram_dp_array #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_re,
  input  logic [AW-1:0]       i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Only the read register is reset; a same-edge write is seen on the next read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sram_axi4_s.sv
// rtl/sram_axi4_s.sv - AXI4 INCR-burst slave memory; SRAM_AXI4_S_ERR_EN enables range/wlast error responses
module sram_axi4_s
  import sram_axi4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32
) (
  input  logic                i_aclk,
  input  logic                i_areset,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic [7:0]          i_awlen,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready
);
  localparam int OFF_W = $clog2(AXI_BEAT_BYTES);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int AW    = $clog2(DEPTH);

  w_state_t         r_wstate;
  r_state_t         r_rstate;
  logic [IDX_W-1:0] r_widx, r_ridx;
  logic [7:0]       r_awlen, r_wcnt, r_arlen, r_rcnt;
  logic             r_werr, r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast;
  resp_t            r_bresp, r_rresp;

  logic             w_win_rng, w_rin_rng, w_wbeat_err, w_we, w_re;
  logic [AW-1:0]    w_waddr, w_raddr;
  logic [DATA_W-1:0] w_arr_q;
  logic             w_unused;

  assign w_unused = &{1'b0, i_awaddr[OFF_W-1:0], i_araddr[OFF_W-1:0]};

`ifdef SRAM_AXI4_S_ERR_EN
  assign w_win_rng   = 32'(r_widx) < DEPTH;
  assign w_rin_rng   = 32'(r_ridx) < DEPTH;
  assign w_waddr     = AW'(r_widx);
  assign w_raddr     = AW'(r_ridx);
  assign w_wbeat_err = !w_win_rng || (i_wlast != (r_wcnt == r_awlen));
  assign o_rdata     = (r_rresp == SLVERR) ? '0 : w_arr_q;
`else
  assign w_win_rng   = 1'b1;
  assign w_rin_rng   = 1'b1;
  assign w_waddr     = AW'(32'(r_widx) % DEPTH);
  assign w_raddr     = AW'(32'(r_ridx) % DEPTH);
  assign w_wbeat_err = 1'b0;
  assign o_rdata     = w_arr_q;
`endif

  assign w_we = (r_wstate == W_DATA) && i_wvalid && w_win_rng;
  assign w_re = (r_rstate == R_LOAD) && w_rin_rng;

  sram_dp_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
    .i_clk   (i_aclk),
    .i_rst   (i_areset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_wdata),
    .i_wstrb (i_wstrb),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_arr_q)
  );

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_wstate <= W_IDLE;  r_awready <= 1'b1;  r_wready <= 1'b0;
      r_bvalid <= 1'b0;    r_bresp   <= OKAY;  r_werr   <= 1'b0;
      r_widx   <= '0;      r_awlen   <= '0;    r_wcnt   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (i_awvalid) begin
          r_widx    <= i_awaddr[ADDR_W-1:OFF_W];
          r_awlen   <= i_awlen;
          r_wcnt    <= '0;
          r_werr    <= 1'b0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (i_wvalid) begin
          r_widx <= r_widx + 1'b1;
          r_wcnt <= r_wcnt + 8'd1;
          if (w_wbeat_err) r_werr <= 1'b1;
          // A short wlast or a missing wlast both close the burst.
          if (i_wlast || (r_wcnt == r_awlen)) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= (r_werr || w_wbeat_err) ? SLVERR : OKAY;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (i_bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_rstate <= R_IDLE;  r_arready <= 1'b1;  r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;    r_rresp   <= OKAY;
      r_ridx   <= '0;      r_arlen   <= '0;    r_rcnt   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (i_arvalid) begin
          r_ridx    <= i_araddr[ADDR_W-1:OFF_W];
          r_arlen   <= i_arlen;
          r_rcnt    <= '0;
          r_arready <= 1'b0;
          r_rstate  <= R_LOAD;
        end
        R_LOAD: begin
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rcnt == r_arlen);
          r_rresp  <= w_rin_rng ? OKAY : SLVERR;
          r_rstate <= R_BEAT;
        end
        R_BEAT: if (i_rready) begin
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
          if (r_rlast) begin
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_ridx   <= r_ridx + 1'b1;
            r_rcnt   <= r_rcnt + 8'd1;
            r_rstate <= R_LOAD;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rlast   = r_rlast;
  assign o_rresp   = r_rresp;
endmodule

// File: tb/tb_sram_axi4_s.sv
// tb/tb_sram_axi4_s.sv - directed bench for sram_axi4_s; SRAM_AXI4_S_ERR_EN selects DEPTH=16 error checks
module tb_sram_axi4_s;
`ifdef SRAM_AXI4_S_ERR_EN
  localparam int DEPTH = 16;
  localparam logic [1:0] LAST_RESP = 2'b10;
`else
  localparam int DEPTH = 32;
  localparam logic [1:0] LAST_RESP = 2'b00;
`endif

  logic        i_aclk = 1'b0;
  logic        i_areset = 1'b1;
  logic [7:0]  i_awaddr = '0, i_awlen = '0, i_araddr = '0, i_arlen = '0;
  logic        i_awvalid = 1'b0, i_wlast = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic        i_arvalid = 1'b0, i_rready = 1'b0;
  logic [63:0] i_wdata = '0;
  logic [7:0]  i_wstrb = '0;
  logic        o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
  logic [1:0]  o_bresp, o_rresp;
  logic [63:0] o_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sram_axi4_s #(.ADDR_W(8), .DATA_W(64), .DEPTH(DEPTH)) dut (
    .i_aclk(i_aclk), .i_areset(i_areset),
    .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  always #5 i_aclk = ~i_aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, 64'(o_awready), 64'd1);
    check({tag, "_arready"}, 64'(o_arready), 64'd1);
    check({tag, "_wready"},  64'(o_wready),  64'd0);
    check({tag, "_bvalid"},  64'(o_bvalid),  64'd0);
    check({tag, "_rvalid"},  64'(o_rvalid),  64'd0);
    check({tag, "_rlast"},   64'(o_rlast),   64'd0);
    check({tag, "_bresp"},   64'(o_bresp),   64'd0);
    check({tag, "_rresp"},   64'(o_rresp),   64'd0);
    check({tag, "_rdata"},   o_rdata,        64'd0);
  endtask

  task automatic aw_send(input logic [7:0] addr, input logic [7:0] len);
    int n;
    @(negedge i_aclk);
    i_awaddr = addr; i_awlen = len; i_awvalid = 1'b1;
    n = 0;
    while (!o_awready && n < 20) begin @(negedge i_aclk); n++; end
    check("aw_ready", 64'(o_awready), 64'd1);
    @(posedge i_aclk); #1 i_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    @(negedge i_aclk);
    i_wdata = data; i_wstrb = strb; i_wlast = last; i_wvalid = 1'b1;
    n = 0;
    while (!o_wready && n < 20) begin @(negedge i_aclk); n++; end
    check("w_ready", 64'(o_wready), 64'd1);
    @(posedge i_aclk); #1 i_wvalid = 1'b0; i_wlast = 1'b0;
  endtask

  // last_at: beat index that carries wlast; beyond len means wlast is never driven.
  task automatic write_burst(input logic [7:0] addr, input logic [7:0] len, input logic [63:0] base,
                             input logic [7:0] strb, input int last_at, input logic [1:0] exp_resp,
                             input int b_stall);
    int nb;
    nb = ((last_at < int'(len)) ? last_at : int'(len)) + 1;
    aw_send(addr, len);
    for (int i = 0; i < nb; i++) w_send(base + 64'(i), strb, i == last_at);
    @(negedge i_aclk);
    check("b_valid", 64'(o_bvalid), 64'd1);
    check("b_resp", 64'(o_bresp), 64'(exp_resp));
    for (int s = 0; s < b_stall; s++) begin
      @(negedge i_aclk);
      check("b_hold_valid", 64'(o_bvalid), 64'd1);
      check("b_hold_resp", 64'(o_bresp), 64'(exp_resp));
    end
    i_bready = 1'b1;
    @(posedge i_aclk); #1 i_bready = 1'b0;
    @(negedge i_aclk);
    check("b_done", 64'(o_bvalid), 64'd0);
  endtask

  // Each beat: one cycle in R_LOAD (rvalid low) then the beat; stall_beat holds rready low 5 cycles.
  task automatic read_burst(input logic [7:0] addr, input logic [7:0] len, input logic [63:0] base,
                            input logic [63:0] step, input logic [1:0] exp_resp, input int stall_beat);
    logic [63:0] exp_d;
    int n;
    @(negedge i_aclk);
    i_araddr = addr; i_arlen = len; i_arvalid = 1'b1;
    n = 0;
    while (!o_arready && n < 20) begin @(negedge i_aclk); n++; end
    check("ar_ready", 64'(o_arready), 64'd1);
    @(posedge i_aclk); #1 i_arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      exp_d = base + step * 64'(i);
      @(negedge i_aclk);
      check("r_gap", 64'(o_rvalid), 64'd0);
      @(negedge i_aclk);
      check("r_valid", 64'(o_rvalid), 64'd1);
      check("r_data", o_rdata, exp_d);
      check("r_last", 64'(o_rlast), 64'(i == int'(len)));
      check("r_resp", 64'(o_rresp), 64'(exp_resp));
      if (i == stall_beat) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge i_aclk);
          check("r_hold_valid", 64'(o_rvalid), 64'd1);
          check("r_hold_data", o_rdata, exp_d);
          check("r_hold_last", 64'(o_rlast), 64'(i == int'(len)));
        end
      end
      i_rready = 1'b1;
      @(posedge i_aclk); #1 i_rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge i_aclk);
    check_idle_outputs("rst");
    i_areset = 1'b0;

    write_burst(8'h08, 8'd0, 64'd1, 8'hFF, 0, 2'b00, 0);
    read_burst(8'h08, 8'd0, 64'd1, 64'd1, 2'b00, -1);

    write_burst(8'h10, 8'd3, 64'd5, 8'hFF, 3, 2'b00, 0);
    read_burst(8'h10, 8'd3, 64'd5, 64'd1, 2'b00, -1);

    write_burst(8'h30, 8'd3, 64'd50, 8'hFF, 1, LAST_RESP, 0);
    read_burst(8'h30, 8'd1, 64'd50, 64'd1, 2'b00, -1);
    write_burst(8'h50, 8'd1, 64'd60, 8'hFF, 9, LAST_RESP, 0);
    read_burst(8'h50, 8'd1, 64'd60, 64'd1, 2'b00, -1);

    write_burst(8'h40, 8'd1, 64'd10, 8'hFF, 1, 2'b00, 3);
    read_burst(8'h40, 8'd1, 64'd10, 64'd1, 2'b00, 1);

    write_burst(8'h60, 8'd0, 64'd0, 8'hFF, 0, 2'b00, 0);
    write_burst(8'h60, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 2'b00, 0);
    read_burst(8'h60, 8'd0, 64'h0000_0000_FFFF_FFFF, 64'd0, 2'b00, -1);

    aw_send(8'h20, 8'd3);
    w_send(64'd200, 8'hFF, 1'b0);
    w_send(64'd201, 8'hFF, 1'b0);
    @(negedge i_aclk);
    i_areset = 1'b1;
    #1 check_idle_outputs("mid_rst");
    @(negedge i_aclk);
    i_areset = 1'b0;
    repeat (3) begin
      @(negedge i_aclk);
      check("post_rst_bvalid", 64'(o_bvalid), 64'd0);
    end
    write_burst(8'h20, 8'd3, 64'd20, 8'hFF, 3, 2'b00, 0);
    read_burst(8'h20, 8'd3, 64'd20, 64'd1, 2'b00, -1);

`ifdef SRAM_AXI4_S_ERR_EN
    read_burst(8'h80, 8'd0, 64'd0, 64'd0, 2'b10, -1);
    write_burst(8'h80, 8'd0, 64'd99, 8'hFF, 0, 2'b10, 0);
    read_burst(8'h78, 8'd0, 64'd0, 64'd0, 2'b00, -1);
`else
    write_burst(8'hF8, 8'd1, 64'd100, 8'hFF, 1, 2'b00, 0);
    read_burst(8'hF8, 8'd1, 64'd100, 64'd1, 2'b00, -1);
    read_burst(8'h00, 8'd0, 64'd101, 64'd0, 2'b00, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
